// File: rtl/rvfi_order_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_order_seq_pkg
// Brief   : Shared types and order classification for the RVFI order sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package rvfi_order_seq_pkg;

    localparam int RVFI_XLEN   = 32;
    localparam int DEPTH_DEF   = 8;
    localparam int IDX_W       = $clog2(DEPTH_DEF);

    typedef struct packed {
        logic [31:0]          insn;
        logic                 trap;
        logic [RVFI_XLEN-1:0] pc_rdata;
        logic [RVFI_XLEN-1:0] pc_wdata;
        logic [63:0]          order;
    } rvfi_seq_entry_t;

    typedef enum logic [1:0] {
        ORD_ACCEPT   = 2'd0,
        ORD_STALE    = 2'd1,
        ORD_OVERFLOW = 2'd2
    } ord_class_e;

    // Modular distance from head: the top half of the 64-bit space is "behind".
    function automatic ord_class_e order_diff(
        input logic [63:0] i_order,
        input logic [63:0] i_head,
        input logic [63:0] i_depth
    );
        logic [63:0] w_diff;
        w_diff = i_order - i_head;
        if (w_diff[63])
            return ORD_STALE;
        else if (w_diff < i_depth)
            return ORD_ACCEPT;
        else
            return ORD_OVERFLOW;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_order_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_order_seq_if
// Brief   : RVFI retire inputs and ordered output stream of the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface rvfi_order_seq_if #(
    parameter int NRET = 1,
    parameter int XLEN = 32
);
    logic [NRET-1:0]      rvfi_valid;
    logic [64*NRET-1:0]   rvfi_order;
    logic [32*NRET-1:0]   rvfi_insn;
    logic [NRET-1:0]      rvfi_trap;
    logic [XLEN*NRET-1:0] rvfi_pc_rdata;
    logic [XLEN*NRET-1:0] rvfi_pc_wdata;

    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_order;
    logic [31:0]          out_insn;
    logic                 out_trap;
    logic [XLEN-1:0]      out_pc_rdata;
    logic [XLEN-1:0]      out_pc_wdata;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
        output out_ready,
        input  out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
        input  out_ready,
        output out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rvfi_order_seq_mem.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_order_seq_mem
// Brief   : Slot store with valid bits, priority-resolved write ports, one read
//           port and one clear port.
// Revision: 1.0 - initial release
// ============================================================================
module rvfi_order_seq_mem
    import rvfi_order_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NRET   = 1,
    parameter int SLOT_W = $clog2(DEPTH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRET-1:0]             i_wr_en,
    input  logic [NRET*SLOT_W-1:0]      i_wr_idx,
    input  rvfi_seq_entry_t [NRET-1:0]  i_wr_data,
    output logic [NRET-1:0]             o_wr_accept,
    input  logic [SLOT_W-1:0]           i_rd_idx,
    output logic                        o_rd_valid,
    output rvfi_seq_entry_t             o_rd_data,
    input  logic                        i_clr_en,
    input  logic [SLOT_W-1:0]           i_clr_idx
);
    logic [DEPTH-1:0] r_valid;
    rvfi_seq_entry_t  r_data [DEPTH];
    logic [NRET-1:0]  w_accept;

    // A lower channel aiming at the same slot wins, whether or not it was accepted.
    always_comb begin
        w_accept = '0;
        for (int j = 0; j < NRET; j++) begin
            w_accept[j] = i_wr_en[j] && !r_valid[i_wr_idx[SLOT_W*j +: SLOT_W]];
            for (int k = 0; k < j; k++) begin
                if (i_wr_en[k] && (i_wr_idx[SLOT_W*k +: SLOT_W] == i_wr_idx[SLOT_W*j +: SLOT_W]))
                    w_accept[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (i_clr_en)
                r_valid[i_clr_idx] <= 1'b0;
            for (int j = 0; j < NRET; j++) begin
                if (w_accept[j])
                    r_valid[i_wr_idx[SLOT_W*j +: SLOT_W]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < NRET; j++) begin
            if (w_accept[j])
                r_data[i_wr_idx[SLOT_W*j +: SLOT_W]] <= i_wr_data[j];
        end
    end

    assign o_wr_accept = w_accept;
    assign o_rd_valid  = r_valid[i_rd_idx];
    assign o_rd_data   = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/rvfi_order_seq.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_order_seq
// Brief   : Reorders RVFI retirements from NRET channels into a strict
//           rvfi_order stream. Optional PC continuity check via
//           RVFI_ORDER_SEQ_PCCHK_EN (adds err_pc).
// Revision: 1.0 - initial release
// ============================================================================
module rvfi_order_seq
    import rvfi_order_seq_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int XLEN  = RVFI_XLEN,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    rvfi_order_seq_if.slave         bus,
    output logic [$clog2(DEPTH):0]  out_count,
    output logic                    err_dup,
    output logic                    err_overflow
`ifdef RVFI_ORDER_SEQ_PCCHK_EN
    ,
    output logic                    err_pc
`endif
);
    localparam int SLOT_W = $clog2(DEPTH);
    localparam int CNT_W  = SLOT_W + 1;

    logic [63:0]                r_head;
    logic [CNT_W-1:0]           r_count;
    logic                       r_err_dup;
    logic                       r_err_ovf;

    logic [NRET-1:0]            w_wr_en;
    logic [NRET-1:0]            w_accept;
    logic [NRET-1:0]            w_stale;
    logic [NRET-1:0]            w_ovf;
    logic [NRET*SLOT_W-1:0]     w_wr_idx;
    rvfi_seq_entry_t [NRET-1:0] w_wr_data;
    rvfi_seq_entry_t            w_rd;
    logic                       w_rd_valid;
    logic                       w_pop;
    logic [CNT_W-1:0]           w_nacc;

    // Every channel is classified against the head as it stood before this cycle's pop.
    always_comb begin
        w_wr_en   = '0;
        w_stale   = '0;
        w_ovf     = '0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        for (int j = 0; j < NRET; j++) begin
            w_wr_data[j].order    = bus.rvfi_order[64*j +: 64];
            w_wr_data[j].insn     = bus.rvfi_insn[32*j +: 32];
            w_wr_data[j].trap     = bus.rvfi_trap[j];
            w_wr_data[j].pc_rdata = bus.rvfi_pc_rdata[XLEN*j +: XLEN];
            w_wr_data[j].pc_wdata = bus.rvfi_pc_wdata[XLEN*j +: XLEN];
            w_wr_idx[SLOT_W*j +: SLOT_W] = bus.rvfi_order[64*j +: SLOT_W];
            case (order_diff(bus.rvfi_order[64*j +: 64], r_head, 64'(DEPTH)))
                ORD_ACCEPT: w_wr_en[j] = bus.rvfi_valid[j];
                ORD_STALE:  w_stale[j] = bus.rvfi_valid[j];
                default:    w_ovf[j]   = bus.rvfi_valid[j];
            endcase
        end
    end

    rvfi_order_seq_mem #(
        .DEPTH  (DEPTH),
        .NRET   (NRET),
        .SLOT_W (SLOT_W)
    ) u_mem (
        .clock       (clock),
        .reset       (reset),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_wr_idx),
        .i_wr_data   (w_wr_data),
        .o_wr_accept (w_accept),
        .i_rd_idx    (r_head[SLOT_W-1:0]),
        .o_rd_valid  (w_rd_valid),
        .o_rd_data   (w_rd),
        .i_clr_en    (w_pop),
        .i_clr_idx   (r_head[SLOT_W-1:0])
    );

    assign w_pop = w_rd_valid && bus.out_ready;

    always_comb begin
        w_nacc = '0;
        for (int j = 0; j < NRET; j++)
            w_nacc = w_nacc + CNT_W'(w_accept[j]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head    <= '0;
            r_count   <= '0;
            r_err_dup <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_pop)
                r_head <= r_head + 64'd1;
            r_count <= r_count + w_nacc - CNT_W'(w_pop);
            if ((|w_stale) || (|(w_wr_en & ~w_accept)))
                r_err_dup <= 1'b1;
            if (|w_ovf)
                r_err_ovf <= 1'b1;
        end
    end

    assign bus.out_valid    = w_rd_valid;
    assign bus.out_order    = w_rd_valid ? w_rd.order    : '0;
    assign bus.out_insn     = w_rd_valid ? w_rd.insn     : '0;
    assign bus.out_trap     = w_rd_valid ? w_rd.trap     : 1'b0;
    assign bus.out_pc_rdata = w_rd_valid ? w_rd.pc_rdata : '0;
    assign bus.out_pc_wdata = w_rd_valid ? w_rd.pc_wdata : '0;
    assign out_count        = r_count;
    assign err_dup          = r_err_dup;
    assign err_overflow     = r_err_ovf;

`ifdef RVFI_ORDER_SEQ_PCCHK_EN
    logic            r_have_prev;
    logic [XLEN-1:0] r_prev_wdata;
    logic            r_err_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_have_prev  <= 1'b0;
            r_prev_wdata <= '0;
            r_err_pc     <= 1'b0;
        end else if (w_pop) begin
            r_have_prev  <= 1'b1;
            r_prev_wdata <= w_rd.pc_wdata;
            if (r_have_prev && (w_rd.pc_rdata != r_prev_wdata))
                r_err_pc <= 1'b1;
        end
    end

    assign err_pc = r_err_pc;

`ifdef RISCV_FORMAL
    always_comb assert (!r_err_pc);
`endif
`endif

endmodule
`default_nettype wire
